// File: rtl/oob_dev_if.sv
// oob_dev_if: GTX-side OOB signals plus user data and status of oob_dev.
// The slave modport is the device; the master modport drives it.
interface oob_dev_if;
    logic        gtx_ready;
    logic        rxcominitdet;
    logic        rxcomwakedet;
    logic        rxelecidle;
    logic        txcomfinish;
    logic        txcominit;
    logic        txcomwake;
    logic        txelecidle;
    logic [31:0] txdata_in;
    logic [3:0]  txcharisk_in;
    logic [31:0] txdata_out;
    logic [3:0]  txcharisk_out;
    logic [31:0] rxdata_in;
    logic [3:0]  rxcharisk_in;
    logic        rxbyteisaligned;
    logic        phy_ready;
    logic        link_up;
    logic        link_down;
    logic        oob_timeout;
    logic [2:0]  state_dbg;

    modport slave (
        input  gtx_ready, rxcominitdet, rxcomwakedet,
        input  rxelecidle, txcomfinish,
        input  txdata_in, txcharisk_in,
        input  rxdata_in, rxcharisk_in, rxbyteisaligned,
        output txcominit, txcomwake, txelecidle,
        output txdata_out, txcharisk_out,
        output phy_ready, link_up, link_down,
        output oob_timeout, state_dbg
    );

    modport master (
        output gtx_ready, rxcominitdet, rxcomwakedet,
        output rxelecidle, txcomfinish,
        output txdata_in, txcharisk_in,
        output rxdata_in, rxcharisk_in, rxbyteisaligned,
        input  txcominit, txcomwake, txelecidle,
        input  txdata_out, txcharisk_out,
        input  phy_ready, link_up, link_down,
        input  oob_timeout, state_dbg
    );
endinterface

// File: rtl/oob_dev.sv
// oob_dev: device-side SATA OOB / link-init emulation.
// OOB_DEV_AUTO_COMINIT_EN: start OOB on gtx_ready rise without COMRESET.
module oob_dev #(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int COMWAKE_TIMEOUT = 16384,
    parameter int ALIGN_TIMEOUT   = 4096
) (
    input logic      clk,
    input logic      rst,
    oob_dev_if.slave bus
);
    localparam int DW = DATA_BYTE_WIDTH * 8;
    localparam int KW = DATA_BYTE_WIDTH;
    localparam logic [DW-1:0] ALIGN_P = DW'(32'h7B4A4ABC);
    localparam logic [DW-1:0] SYNC_P  = DW'(32'hB5B5957C);
    localparam logic [KW-1:0] PRIM_K  = KW'(4'b0001);
    localparam logic [15:0] CW_LAST = 16'(COMWAKE_TIMEOUT - 1);
    localparam logic [15:0] AL_LAST = 16'(ALIGN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEND_COMINIT = 3'd1,
        WAIT_COMWAKE = 3'd2,
        SEND_COMWAKE = 3'd3,
        SEND_ALIGN   = 3'd4,
        SEND_SYNC    = 3'd5,
        READY        = 3'd6
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [15:0] tmo_cnt;
    logic [1:0]  sync_cnt;
    logic [2:0]  idle_cnt;
    logic        is_align;
    logic        rx_align;
    logic        sync_word;
    logic        tmo_hit;
    logic        restart_ok;
    logic        ev_up;
    logic        ev_down;
    logic        ev_tmo;
    logic        auto_pend;

    assign is_align  = (bus.rxdata_in == ALIGN_P) &&
                       (bus.rxcharisk_in == PRIM_K);
    assign rx_align  = bus.rxbyteisaligned && is_align;
    assign sync_word = bus.rxbyteisaligned && !is_align;

    assign restart_ok = (state == WAIT_COMWAKE) ||
                        (state == SEND_COMWAKE) ||
                        (state == SEND_ALIGN)   ||
                        (state == SEND_SYNC)    ||
                        (state == READY);

    assign tmo_hit =
        (((state == SEND_COMINIT) || (state == WAIT_COMWAKE) ||
          (state == SEND_COMWAKE)) && (tmo_cnt == CW_LAST)) ||
        ((state == SEND_ALIGN) && (tmo_cnt == AL_LAST));

    assign bus.state_dbg = state;

`ifdef OOB_DEV_AUTO_COMINIT_EN
    logic gtx_q;

    // Arm a single self-start per gtx_ready rising edge while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gtx_q     <= 1'b0;
            auto_pend <= 1'b0;
        end else begin
            gtx_q     <= bus.gtx_ready;
            auto_pend <= bus.gtx_ready && (nxt == IDLE) &&
                         ((bus.gtx_ready && !gtx_q) || auto_pend);
        end
    end
`else
    assign auto_pend = 1'b0;
`endif

    // Next state and event decode, highest priority first.
    always_comb begin
        nxt     = state;
        ev_up   = 1'b0;
        ev_down = 1'b0;
        ev_tmo  = 1'b0;
        if (!bus.gtx_ready) begin
            nxt     = IDLE;
            ev_down = (state == READY);
        end else if (bus.rxcominitdet && restart_ok) begin
            nxt     = SEND_COMINIT;
            ev_down = (state == READY);
        end else if (tmo_hit) begin
            nxt    = IDLE;
            ev_tmo = 1'b1;
        end else begin
            unique case (state)
                IDLE:
                    if (bus.rxcominitdet || auto_pend)
                        nxt = SEND_COMINIT;
                SEND_COMINIT:
                    if (bus.txcomfinish) nxt = WAIT_COMWAKE;
                WAIT_COMWAKE:
                    if (bus.rxcomwakedet) nxt = SEND_COMWAKE;
                SEND_COMWAKE:
                    if (bus.txcomfinish) nxt = SEND_ALIGN;
                SEND_ALIGN:
                    if (rx_align) nxt = SEND_SYNC;
                SEND_SYNC:
                    if (sync_word && (sync_cnt == 2'd2)) begin
                        nxt   = READY;
                        ev_up = 1'b1;
                    end
                READY:
                    if (bus.rxelecidle && (idle_cnt == 3'd7)) begin
                        nxt     = IDLE;
                        ev_down = 1'b1;
                    end
                default: nxt = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs driven from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            sync_cnt          <= '0;
            idle_cnt          <= '0;
            bus.txcominit     <= 1'b0;
            bus.txcomwake     <= 1'b0;
            bus.txelecidle    <= 1'b1;
            bus.txdata_out    <= '0;
            bus.txcharisk_out <= '0;
            bus.phy_ready     <= 1'b0;
            bus.link_up       <= 1'b0;
            bus.link_down     <= 1'b0;
            bus.oob_timeout   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                tmo_cnt  <= '0;
                sync_cnt <= '0;
                idle_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (state == SEND_SYNC)
                    sync_cnt <= sync_word ? sync_cnt + 2'd1 : 2'd0;
                if (state == READY)
                    idle_cnt <= bus.rxelecidle ? idle_cnt + 3'd1 : 3'd0;
            end
            bus.txcominit <= (nxt == SEND_COMINIT) &&
                             (state != SEND_COMINIT);
            bus.txcomwake <= (nxt == SEND_COMWAKE) &&
                             (state != SEND_COMWAKE);
            bus.link_up     <= ev_up;
            bus.link_down   <= ev_down;
            bus.oob_timeout <= ev_tmo;
            bus.phy_ready   <= (nxt == READY) && bus.rxbyteisaligned;
            unique case (nxt)
                SEND_ALIGN: begin
                    bus.txelecidle    <= 1'b0;
                    bus.txdata_out    <= ALIGN_P;
                    bus.txcharisk_out <= PRIM_K;
                end
                SEND_SYNC: begin
                    bus.txelecidle    <= 1'b0;
                    bus.txdata_out    <= SYNC_P;
                    bus.txcharisk_out <= PRIM_K;
                end
                READY: begin
                    bus.txelecidle    <= 1'b0;
                    bus.txdata_out    <= bus.txdata_in;
                    bus.txcharisk_out <= bus.txcharisk_in;
                end
                default: begin
                    bus.txelecidle    <= 1'b1;
                    bus.txdata_out    <= '0;
                    bus.txcharisk_out <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oob_dev.sv
// tb_oob_dev: directed checks of the oob_dev handshake,
// timeouts, link loss, passthrough and reset.
module tb_oob_dev;
    localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_P  = 32'hB5B5957C;
    localparam logic [31:0] D_WORD  = 32'h4A4A4A4A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic saw;

    oob_dev_if bus();

    oob_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic go_idle();
        bus.gtx_ready = 1'b0;
        step();
        chk("go_idle_state", 32'(bus.state_dbg), 0);
    endtask

    task automatic reach_align();
        bus.gtx_ready    = 1'b1;
        bus.rxcominitdet = 1'b1;
        step();
        bus.rxcominitdet = 1'b0;
        chk("cominit_state", 32'(bus.state_dbg), 1);
        chk("cominit_pulse", 32'(bus.txcominit), 1);
        chk("cominit_eidle", 32'(bus.txelecidle), 1);
        step();
        chk("cominit_1cyc", 32'(bus.txcominit), 0);
        bus.txcomfinish = 1'b1;
        step();
        bus.txcomfinish = 1'b0;
        chk("wait_cw_state", 32'(bus.state_dbg), 2);
        bus.rxcomwakedet = 1'b1;
        step();
        bus.rxcomwakedet = 1'b0;
        chk("comwake_state", 32'(bus.state_dbg), 3);
        chk("comwake_pulse", 32'(bus.txcomwake), 1);
        step();
        chk("comwake_1cyc", 32'(bus.txcomwake), 0);
        bus.txcomfinish = 1'b1;
        step();
        bus.txcomfinish = 1'b0;
        chk("align_state", 32'(bus.state_dbg), 4);
        chk("align_eidle", 32'(bus.txelecidle), 0);
        chk("align_data", bus.txdata_out, ALIGN_P);
        chk("align_k", 32'(bus.txcharisk_out), 1);
    endtask

    task automatic rx_word(input logic [31:0] d, input logic [3:0] k);
        bus.rxdata_in    = d;
        bus.rxcharisk_in = k;
        step();
    endtask

    task automatic reach_ready();
        reach_align();
        rx_word(ALIGN_P, 4'b0001);
        repeat (3) rx_word(D_WORD, 4'b0000);
        chk("ready_state", 32'(bus.state_dbg), 6);
        chk("ready_up", 32'(bus.link_up), 1);
    endtask

    initial begin
        bus.gtx_ready       = 1'b0;
        bus.rxcominitdet    = 1'b0;
        bus.rxcomwakedet    = 1'b0;
        bus.rxelecidle      = 1'b0;
        bus.txcomfinish     = 1'b0;
        bus.txdata_in       = '0;
        bus.txcharisk_in    = '0;
        bus.rxdata_in       = '0;
        bus.rxcharisk_in    = '0;
        bus.rxbyteisaligned = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_state", 32'(bus.state_dbg), 0);
        chk("rst_eidle", 32'(bus.txelecidle), 1);
        chk("rst_data", bus.txdata_out, 0);
        chk("rst_phy", 32'(bus.phy_ready), 0);
        chk("rst_cominit", 32'(bus.txcominit), 0);
        chk("rst_pulses", {29'd0, bus.link_up,
            bus.link_down, bus.oob_timeout}, 0);
        rst = 1'b0;
        step();

        bus.gtx_ready = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            step();
            if (bus.txcominit) saw = 1'b1;
        end
`ifdef OOB_DEV_AUTO_COMINIT_EN
        chk("auto_cominit", 32'(saw), 1);
        chk("auto_state", 32'(bus.state_dbg), 1);
`else
        chk("auto_cominit", 32'(saw), 0);
        chk("auto_state", 32'(bus.state_dbg), 0);
`endif
        go_idle();

        reach_align();
        repeat (2) rx_word(32'h0, 4'b0000);
        chk("align_hold", 32'(bus.state_dbg), 4);
        rx_word(ALIGN_P, 4'b0001);
        chk("sync_state", 32'(bus.state_dbg), 5);
        chk("sync_data", bus.txdata_out, SYNC_P);
        chk("sync_k", 32'(bus.txcharisk_out), 1);
        repeat (2) rx_word(D_WORD, 4'b0000);
        chk("sync_2w", 32'(bus.state_dbg), 5);
        chk("sync_2w_up", 32'(bus.link_up), 0);
        rx_word(D_WORD, 4'b0000);
        chk("up_state", 32'(bus.state_dbg), 6);
        chk("up_pulse", 32'(bus.link_up), 1);
        chk("up_phy", 32'(bus.phy_ready), 1);

        bus.txdata_in    = 32'h12345678;
        bus.txcharisk_in = 4'b0000;
        step();
        chk("up_1cyc", 32'(bus.link_up), 0);
        chk("pass_data", bus.txdata_out, 32'h12345678);
        chk("pass_k", 32'(bus.txcharisk_out), 0);
        bus.txdata_in    = 32'hDEADBEEF;
        bus.txcharisk_in = 4'b0001;
        step();
        chk("pass_data2", bus.txdata_out, 32'hDEADBEEF);
        chk("pass_k2", 32'(bus.txcharisk_out), 1);

        bus.rxelecidle = 1'b1;
        repeat (7) step();
        chk("eidle7_state", 32'(bus.state_dbg), 6);
        chk("eidle7_down", 32'(bus.link_down), 0);
        step();
        bus.rxelecidle = 1'b0;
        chk("eidle8_state", 32'(bus.state_dbg), 0);
        chk("eidle8_down", 32'(bus.link_down), 1);
        chk("eidle8_phy", 32'(bus.phy_ready), 0);
        go_idle();

        reach_ready();
        bus.rxcominitdet = 1'b1;
        step();
        bus.rxcominitdet = 1'b0;
        chk("rdy_ci_state", 32'(bus.state_dbg), 1);
        chk("rdy_ci_down", 32'(bus.link_down), 1);
        chk("rdy_ci_pulse", 32'(bus.txcominit), 1);
        chk("rdy_ci_phy", 32'(bus.phy_ready), 0);
        go_idle();

        reach_align();
        rx_word(ALIGN_P, 4'b0001);
        repeat (2) rx_word(D_WORD, 4'b0000);
        rx_word(ALIGN_P, 4'b0001);
        chk("rs_align", 32'(bus.state_dbg), 5);
        repeat (2) rx_word(D_WORD, 4'b0000);
        chk("rs_2w", 32'(bus.state_dbg), 5);
        chk("rs_2w_up", 32'(bus.link_up), 0);
        rx_word(D_WORD, 4'b0000);
        chk("rs_3w", 32'(bus.state_dbg), 6);
        chk("rs_3w_up", 32'(bus.link_up), 1);
        go_idle();

        reach_align();
        bus.rxdata_in    = 32'h0;
        bus.rxcharisk_in = 4'b0000;
        repeat (4095) step();
        chk("atmo_before", 32'(bus.state_dbg), 4);
        chk("atmo_nopulse", 32'(bus.oob_timeout), 0);
        step();
        chk("atmo_state", 32'(bus.state_dbg), 0);
        chk("atmo_pulse", 32'(bus.oob_timeout), 1);
        chk("atmo_eidle", 32'(bus.txelecidle), 1);
        repeat (3) step();
        chk("atmo_stay", 32'(bus.state_dbg), 0);
        chk("atmo_1cyc", 32'(bus.oob_timeout), 0);
        go_idle();

        bus.gtx_ready    = 1'b1;
        bus.rxcominitdet = 1'b1;
        step();
        bus.rxcominitdet = 1'b0;
        bus.txcomfinish  = 1'b1;
        step();
        bus.txcomfinish  = 1'b0;
        chk("cwtmo_entry", 32'(bus.state_dbg), 2);
        repeat (16383) step();
        chk("cwtmo_before", 32'(bus.state_dbg), 2);
        step();
        chk("cwtmo_state", 32'(bus.state_dbg), 0);
        chk("cwtmo_pulse", 32'(bus.oob_timeout), 1);
        go_idle();

        reach_ready();
        bus.gtx_ready = 1'b0;
        step();
        chk("gtx_lo_state", 32'(bus.state_dbg), 0);
        chk("gtx_lo_down", 32'(bus.link_down), 1);
        chk("gtx_lo_phy", 32'(bus.phy_ready), 0);
        step();

        reach_align();
        bus.rxcominitdet = 1'b1;
        rst = 1'b1;
        step();
        bus.rxcominitdet = 1'b0;
        chk("mrst_state", 32'(bus.state_dbg), 0);
        chk("mrst_eidle", 32'(bus.txelecidle), 1);
        chk("mrst_data", bus.txdata_out, 0);
        chk("mrst_ci", 32'(bus.txcominit), 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
